// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard event queue.
// Register map offsets are relative to the block's BASE_ADDR.
package ps2_kbd_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam logic [31:0] REG_STATUS = 32'd0;
  localparam logic [31:0] REG_DATA   = 32'd4;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_MSB = 15;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous FIFO of parsed key events. A pop on a full FIFO frees the
// slot for a same-cycle push; a pop on an empty FIFO is ignored.
module ps2_evt_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  ps2_evt_t      din,
  output ps2_evt_t      dout,
  output logic          full,
  output logic          empty,
  output logic          push_ok,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  ps2_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_fifo.sv
// Memory-mapped PS/2 key-event queue: edge detect, E0/F0 prefix parser and
// STATUS/DATA bus decode. Define PS2_BREAK_FILTER_EN to drop break events.
module ps2_key_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        kb_valid,
  input  logic [7:0]  kb_code,
  input  logic [31:0] bus_addr,
  input  logic        bus_re,
  input  logic        bus_we,
  input  logic [31:0] bus_wd,
  output logic [31:0] bus_rd,
  output logic        hit,
  output logic        not_empty,
  output logic [7:0]  last_code
);

  localparam int AW = $clog2(DEPTH);

  logic          kv_q;
  logic          ext_p;
  logic          brk_p;
  logic          ovf;
  logic          byte_stb;
  logic          evt_stb;
  logic          push;
  logic          pop;
  logic          push_ok;
  logic          full;
  logic          empty;
  logic          brk_bit;
  logic          sel_status;
  logic          sel_data;
  logic [AW:0]   count;
  ps2_evt_t      evt;
  ps2_evt_t      head;
  logic          unused_bits;

  assign byte_stb   = kb_valid & ~kv_q;
  assign evt_stb    = byte_stb && (kb_code != PS2_PREFIX_EXT) && (kb_code != PS2_PREFIX_BRK);
  assign evt        = '{ext: ext_p, brk: brk_p, code: kb_code};
  assign sel_status = (bus_addr == BASE_ADDR + REG_STATUS);
  assign sel_data   = (bus_addr == BASE_ADDR + REG_DATA);
  assign hit        = sel_status | sel_data;
  assign pop        = sel_data & bus_re;
  assign not_empty  = ~empty;

`ifdef PS2_BREAK_FILTER_EN
  assign push    = evt_stb & ~brk_p;
  assign brk_bit = 1'b0;
`else
  assign push    = evt_stb;
  assign brk_bit = head.brk;
`endif

  assign unused_bits = &{1'b0, bus_wd[31:3], bus_wd[1:0], head.brk};

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (evt),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .push_ok (push_ok),
    .count   (count)
  );

  // Prefix flags clear on every non-prefix byte, even if the event is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kv_q      <= 1'b0;
      ext_p     <= 1'b0;
      brk_p     <= 1'b0;
      ovf       <= 1'b0;
      last_code <= 8'h00;
    end else begin
      kv_q <= kb_valid;
      if (byte_stb) begin
        if (kb_code == PS2_PREFIX_EXT) begin
          ext_p <= 1'b1;
        end else if (kb_code == PS2_PREFIX_BRK) begin
          brk_p <= 1'b1;
        end else begin
          ext_p <= 1'b0;
          brk_p <= 1'b0;
        end
      end
      if (push_ok) last_code <= kb_code;
      if (push && !push_ok)
        ovf <= 1'b1;
      else if (sel_status && bus_we && bus_wd[STAT_OVF])
        ovf <= 1'b0;
    end
  end

  always_comb begin
    bus_rd = 32'h0;
    if (sel_status) begin
      bus_rd[STAT_NOT_EMPTY]                = ~empty;
      bus_rd[STAT_FULL]                     = full;
      bus_rd[STAT_OVF]                      = ovf;
      bus_rd[STAT_COUNT_MSB:STAT_COUNT_LSB] = 8'(count);
    end else if (sel_data && !empty) begin
      bus_rd = {1'b1, 21'b0, head.ext, brk_bit, head.code};
    end
  end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo; expected DATA words are queued in a
// scoreboard as bytes are fed and popped as the CPU reads them.
module tb_ps2_key_fifo;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'd10;
  localparam logic [31:0] ST    = BASE;
  localparam logic [31:0] DA    = BASE + 32'd4;

  logic        clk;
  logic        rst;
  logic        kb_valid;
  logic [7:0]  kb_code;
  logic [31:0] bus_addr;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_wd;
  logic [31:0] bus_rd;
  logic        hit;
  logic        not_empty;
  logic [7:0]  last_code;

  logic [31:0] sb[$];
  bit          m_ext;
  bit          m_brk;
  bit          m_ovf;
  logic [7:0]  m_last;
  int          errors = 0;
  int          checks = 0;

  ps2_key_fifo #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .kb_valid  (kb_valid),
    .kb_code   (kb_code),
    .bus_addr  (bus_addr),
    .bus_re    (bus_re),
    .bus_we    (bus_we),
    .bus_wd    (bus_wd),
    .bus_rd    (bus_rd),
    .hit       (hit),
    .not_empty (not_empty),
    .last_code (last_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = 32'h0;
    s[0]    = (sb.size() != 0);
    s[1]    = (sb.size() == DEPTH);
    s[2]    = m_ovf;
    s[15:8] = 8'(sb.size());
    return s;
  endfunction

  // Reference parser: prefixes set flags, anything else forms one event
  task automatic model_byte(input logic [7:0] code);
    if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (!m_brk) begin
`else
      begin
`endif
        if (sb.size() < DEPTH) begin
          sb.push_back({1'b1, 21'b0, m_ext, m_brk, code});
          m_last = code;
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_ovf  = 1'b0;
    m_last = 8'h00;
  endtask

  // All tasks start and end 1 time unit after a rising clock edge
  task automatic apply_stimulus(input logic [7:0] code, input int hold);
    kb_valid = 1'b1;
    kb_code  = code;
    model_byte(code);
    repeat (hold) @(posedge clk);
    #1 kb_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] exp;
    bus_addr = DA;
    bus_re   = 1'b1;
    #1;
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    check_output(tag, bus_rd, exp);
    @(posedge clk);
    #1 bus_re = 1'b0;
    bus_addr  = 32'h0;
  endtask

  task automatic read_status(input string tag);
    bus_addr = ST;
    #1 check_output(tag, bus_rd, exp_status());
    @(posedge clk);
    #1 bus_addr = 32'h0;
  endtask

  task automatic write_status(input logic [31:0] wd);
    bus_addr = ST;
    bus_we   = 1'b1;
    bus_wd   = wd;
    if (wd[2]) m_ovf = 1'b0;
    @(posedge clk);
    #1 bus_we = 1'b0;
    bus_wd    = 32'h0;
    bus_addr  = 32'h0;
  endtask

  // Byte strobe and DATA pop in the same cycle; model pops before pushing
  task automatic push_and_pop(input logic [7:0] code);
    logic [31:0] exp;
    kb_valid = 1'b1;
    kb_code  = code;
    bus_addr = DA;
    bus_re   = 1'b1;
    #1;
    exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
    check_output("combo_pop", bus_rd, exp);
    model_byte(code);
    @(posedge clk);
    #1 kb_valid = 1'b0;
    bus_re   = 1'b0;
    bus_addr = 32'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    kb_valid = 1'b0;
    kb_code  = 8'h00;
    bus_addr = ST;
    bus_re   = 1'b0;
    bus_we   = 1'b0;
    bus_wd   = 32'h0;
    model_reset();
    #1;
    check_output("rst_status", bus_rd, 32'h0);
    check_output("rst_not_empty", {31'b0, not_empty}, 32'h0);
    check_output("rst_hit_status", {31'b0, hit}, 32'h1);
    check_output("rst_last_code", {24'b0, last_code}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus_addr = 32'h0;

    $display("[TB] single byte held 3 cycles");
    apply_stimulus(8'h1C, 3);
    read_status("one_evt_status");
    check_output("one_evt_last_code", {24'b0, last_code}, {24'b0, m_last});
    read_data("one_evt_data");
    read_status("one_evt_drained");

    $display("[TB] extended break sequence");
    apply_stimulus(8'hE0, 1);
    apply_stimulus(8'hF0, 1);
    apply_stimulus(8'h75, 1);
    check_output("ext_brk_not_empty", {31'b0, not_empty}, {31'b0, sb.size() != 0});
    check_output("ext_brk_last_code", {24'b0, last_code}, {24'b0, m_last});
    read_data("ext_brk_data");
    apply_stimulus(8'hE1, 1);
    read_data("e1_ordinary");

    $display("[TB] overflow");
    for (int i = 0; i < DEPTH + 2; i++) apply_stimulus(8'h20 + 8'(i), 1);
    read_status("ovf_status");
    write_status(32'h4);
    read_status("ovf_cleared");
    push_and_pop(8'h55);
    read_status("combo_status");
    check_output("combo_last_code", {24'b0, last_code}, {24'b0, m_last});
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("drain_%0d", i));

    $display("[TB] empty read and address miss");
    read_data("empty_read");
    read_status("empty_status");
    apply_stimulus(8'h3A, 1);
    read_data("after_empty_read");
    bus_addr = BASE + 32'd8;
    #1;
    check_output("miss_hit", {31'b0, hit}, 32'h0);
    check_output("miss_rd", bus_rd, 32'h0);
    bus_addr = DA;
    #1 check_output("data_hit", {31'b0, hit}, 32'h1);
    @(posedge clk);
    #1 bus_addr = 32'h0;

    $display("[TB] reset discards pending prefix");
    apply_stimulus(8'h44, 1);
    apply_stimulus(8'hE0, 1);
    #2 rst = 1'b0;
    model_reset();
    bus_addr = ST;
    #1;
    check_output("midrst_status", bus_rd, 32'h0);
    check_output("midrst_not_empty", {31'b0, not_empty}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus_addr = 32'h0;
    @(posedge clk);
    #1;
    apply_stimulus(8'h6B, 1);
    read_data("post_rst_data");
    read_status("post_rst_status");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
